reg_wb_ctrl: RTL and testbench
==============================

# reg_wb_ctrl

Writeback controller that drives the single write port of the 32×64-bit GPR file. It merges ALU results (fixed timing, no backpressure) with load results from the memory unit, which arrive late and are buffered in a small FIFO. It also keeps a per-register busy scoreboard for outstanding loads, which the issue/hazard logic uses. It sits at the end of the pipeline and is the only agent that writes the register file.

## Interface

Parameters:

- `DEPTH`, 4: load-result FIFO entries (power of two, ≥2).
- `STARVE_LIMIT`, 8: cycles a FIFO head may wait behind ALU writes before the ALU is stalled.
- `REG_FILE_BITS`, 5: register index width.
- `REG_SIZE`, 64: data width.

Ports (clock and reset first; one clock; reset is asynchronous and active-low):

- `clk` in 1: single clock, all state on posedge.
- `rst_n` in 1: asynchronous active-low reset.
- `alu_valid` in 1: ALU result present this cycle.
- `alu_rd` in 5: ALU destination register.
- `alu_data` in 64: ALU result.
- `alu_stall` out 1: registered; ALU must hold `alu_valid`=0 while high.
- `mem_valid` in 1: load result offered.
- `mem_ready` out 1: FIFO can accept.
- `mem_rd` in 5: load destination register.
- `mem_data` in 64: load data.
- `ld_issue_valid` in 1: load issued this cycle.
- `ld_issue_rd` in 5: its destination register.
- `busy` out 32: scoreboard, bit i = load to xi outstanding.
- `rf_we` out 1: register-file write enable (registered).
- `rf_write_num` out 5: register-file write index (registered).
- `rf_input_data` out 64: register-file write data (registered).
- `err` out 1: sticky protocol-violation flag.

## Operation

- **Reset values:** `rf_we`=0, `rf_write_num`=0, `rf_input_data`=0, `alu_stall`=0, `busy`=0, `err`=0, FIFO empty, wait counter 0. `mem_ready`=1 once reset is released.
- **FIFO push:**
  - `mem_valid && mem_ready` accepts the load.
  - Accepted loads with `mem_rd`=0 are dropped and never enqueued.
  - `mem_ready` = (count < DEPTH), combinational from registered state.
- **Write selection each cycle, in priority order:**
  1. `alu_stall`=1 and FIFO non-empty: pop the FIFO head.
  2. `alu_valid` && `alu_rd`≠0: write the ALU result.
  3. FIFO non-empty: pop the FIFO head.
  4. Otherwise: no write.
- **Write registers:** the selected write is loaded into `rf_we`/`rf_write_num`/`rf_input_data` at posedge. With no selection, `rf_we`=0 and num/data hold their previous values.
- **x0:** writes to x0 are never issued. `busy[0]` is constantly 0.
- **Stall protocol violation:** `alu_valid`=1 while `alu_stall`=1 sets `err`, which holds until reset. The ALU result is discarded in that cycle.
- **Push and pop in the same cycle:** legal, including when full. A full FIFO that pops keeps `mem_ready`=0 in that cycle; there is no bypass.
- **Wait counter:**
  - Increments while the FIFO is non-empty and no pop occurs.
  - Clears on pop or when the FIFO is empty.
  - Saturates at `STARVE_LIMIT`.
- **`alu_stall` next value** = (count_next == DEPTH) || (wait_next ≥ STARVE_LIMIT).
- **Scoreboard:**
  - `ld_issue_valid` sets `busy[ld_issue_rd]`.
  - A FIFO pop to rd clears `busy[rd]`.
  - Set and clear of the same rd in one cycle: set wins.
  - Issue of a load to an already-busy rd is illegal and sets `err`.
- **Reset mid-operation:** FIFO contents and the scoreboard are discarded immediately. Any `rf_we` pulse in flight is cleared asynchronously.

## Timing

- **Register-file commit:** outputs change at posedge and are held for the full cycle. The register file commits at the following negedge. A reader sampling after that negedge sees the value in the same cycle.
- **ALU latency:** result at posedge N gives `rf_we` in cycle N+1.
- **Load latency:** accepted at edge N gives earliest `rf_we` in cycle N+2. The pop occurs in cycle N+1.
- **Scoreboard timing:** `busy[rd]` falls at the same posedge at which the popped entry's `rf_we` rises. `busy` rises the cycle after `ld_issue_valid`.
- **Throughput:** one register-file write per cycle.

## Test plan

- **Reset:** assert `rst_n`=0 mid-cycle with the FIFO holding 2 entries. Required: all outputs go to reset values immediately; after release, `mem_ready`=1 and `busy`=0.
- **ALU path:** `alu_valid`, rd=5, data=0xDEAD_BEEF at edge N. Required: `rf_we`=1, num=5, data=0xDEADBEEF in cycle N+1. A separate ALU write with rd=0 gives `rf_we`=0.
- **Load path:**
  - Issue a load to x7, then deliver `mem_data`=0x1234 with no ALU traffic.
  - Required: `busy[7]`=1 until `rf_we`=1/num=7, two cycles after accept; then `busy[7]`=0.
- **Starvation:**
  - Drive `alu_valid` every cycle with one load queued.
  - Required: `alu_stall` rises after 8 waiting cycles; the next cycle pops the load.
  - Driving `alu_valid` during the stall sets `err`=1.
- **Full FIFO:**
  - Keep the ALU busy and push 4 loads.
  - Required: `mem_ready`=0 at count=4 and `alu_stall`=1 on the next cycle.
  - All 4 loads are written in FIFO order, then `mem_ready`=1 again.
- **Scoreboard collision:** `ld_issue_rd`=9 and a pop to x9 in the same cycle. Required: `busy[9]` stays 1.

Source files
------------

// File: rtl/reg_wb_ctrl.sv
// reg_wb_ctrl: writeback controller for the 32x64 GPR file.
// Merges fixed-latency ALU results with late load results (buffered in a
// small FIFO), arbitrates the single register-file write port, and keeps a
// per-register busy scoreboard for loads that are still outstanding.
module reg_wb_ctrl #(
    parameter int DEPTH         = 4,
    parameter int STARVE_LIMIT  = 8,
    parameter int REG_FILE_BITS = 5,
    parameter int REG_SIZE      = 64
) (
    input  logic                        clk,
    input  logic                        rst_n,
    input  logic                        alu_valid,
    input  logic [REG_FILE_BITS-1:0]    alu_rd,
    input  logic [REG_SIZE-1:0]         alu_data,
    output logic                        alu_stall,
    input  logic                        mem_valid,
    output logic                        mem_ready,
    input  logic [REG_FILE_BITS-1:0]    mem_rd,
    input  logic [REG_SIZE-1:0]         mem_data,
    input  logic                        ld_issue_valid,
    input  logic [REG_FILE_BITS-1:0]    ld_issue_rd,
    output logic [2**REG_FILE_BITS-1:0] busy,
    output logic                        rf_we,
    output logic [REG_FILE_BITS-1:0]    rf_write_num,
    output logic [REG_SIZE-1:0]         rf_input_data,
    output logic                        err
);

    localparam int NREGS  = 2**REG_FILE_BITS;
    localparam int PTR_W  = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CNT_W  = $clog2(DEPTH + 1);
    localparam int WAIT_W = $clog2(STARVE_LIMIT + 1);
    localparam logic [CNT_W-1:0]  DEPTH_C = CNT_W'(DEPTH);
    localparam logic [WAIT_W-1:0] LIMIT_C = WAIT_W'(STARVE_LIMIT);

    // Load-result FIFO storage and bookkeeping
    logic [REG_FILE_BITS-1:0] r_fifo_rd   [DEPTH];
    logic [REG_SIZE-1:0]      r_fifo_data [DEPTH];
    logic [PTR_W-1:0]         r_wr_ptr;
    logic [PTR_W-1:0]         r_rd_ptr;
    logic [CNT_W-1:0]         r_count;
    logic [WAIT_W-1:0]        r_wait;
    logic                     r_alu_stall;
    logic                     r_err;
    logic [NREGS-1:1]         r_busy;

    // Register-file write port
    logic                     r_rf_we;
    logic [REG_FILE_BITS-1:0] r_rf_write_num;
    logic [REG_SIZE-1:0]      r_rf_input_data;

    logic                     w_empty;
    logic                     w_push;
    logic                     w_alu_wr;
    logic                     w_pop;
    logic [REG_FILE_BITS-1:0] w_head_rd;
    logic [REG_SIZE-1:0]      w_head_data;
    logic [CNT_W-1:0]         w_count_next;
    logic [WAIT_W-1:0]        w_wait_next;
    logic                     w_stall_next;
    logic                     w_err_next;
    logic [NREGS-1:1]         w_busy_next;

    assign w_empty     = (r_count == '0);
    assign mem_ready   = (r_count < DEPTH_C);
    // Loads targeting x0 are accepted but never enqueued.
    assign w_push      = mem_valid && mem_ready && (mem_rd != '0);
    assign w_head_rd   = r_fifo_rd[r_rd_ptr];
    assign w_head_data = r_fifo_data[r_rd_ptr];

    // An ALU result offered while stalled is discarded (and flagged below).
    assign w_alu_wr = alu_valid && (alu_rd != '0) && !r_alu_stall;
    // Pop when stalled, or when the ALU is not using the write port.
    // w_alu_wr already excludes the stalled case, so the two never coincide.
    assign w_pop    = !w_empty && (r_alu_stall || !w_alu_wr);

    assign w_count_next = r_count + CNT_W'(w_push) - CNT_W'(w_pop);

    // Starvation counter: counts cycles the FIFO head waits, saturating.
    always_comb begin
        w_wait_next = r_wait;
        if (w_empty || w_pop) begin
            w_wait_next = '0;
        end else if (r_wait < LIMIT_C) begin
            w_wait_next = r_wait + WAIT_W'(1);
        end
    end

    assign w_stall_next = (w_count_next == DEPTH_C) || (w_wait_next >= LIMIT_C);

    // Sticky error: ALU activity during stall, or a load issued to a busy rd.
    assign w_err_next = r_err
                      || (alu_valid && r_alu_stall)
                      || (ld_issue_valid && busy[ld_issue_rd]);

    // Per-register scoreboard next state; an issue beats a same-cycle pop.
    genvar gi;
    generate
        for (gi = 1; gi < NREGS; gi++) begin : g_busy
            assign w_busy_next[gi] =
                (ld_issue_valid && (ld_issue_rd == REG_FILE_BITS'(gi))) ? 1'b1 :
                (w_pop && (w_head_rd == REG_FILE_BITS'(gi)))            ? 1'b0 :
                r_busy[gi];
        end
    endgenerate

    assign busy = {r_busy, 1'b0};

    // FIFO payload storage; no reset needed, validity lives in r_count.
    always_ff @(posedge clk) begin
        if (w_push) begin
            r_fifo_rd[r_wr_ptr]   <= mem_rd;
            r_fifo_data[r_wr_ptr] <= mem_data;
        end
    end

    // FIFO pointers, counters, stall, scoreboard and error state.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wr_ptr    <= '0;
            r_rd_ptr    <= '0;
            r_count     <= '0;
            r_wait      <= '0;
            r_alu_stall <= 1'b0;
            r_err       <= 1'b0;
            r_busy      <= '0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + PTR_W'(1);
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + PTR_W'(1);
            end
            r_count     <= w_count_next;
            r_wait      <= w_wait_next;
            r_alu_stall <= w_stall_next;
            r_err       <= w_err_next;
            r_busy      <= w_busy_next;
        end
    end

    // Register-file write port: load the selected write, hold num/data when idle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_rf_we         <= 1'b0;
            r_rf_write_num  <= '0;
            r_rf_input_data <= '0;
        end else begin
            r_rf_we <= w_pop || w_alu_wr;
            if (w_pop) begin
                r_rf_write_num  <= w_head_rd;
                r_rf_input_data <= w_head_data;
            end else if (w_alu_wr) begin
                r_rf_write_num  <= alu_rd;
                r_rf_input_data <= alu_data;
            end
        end
    end

    assign alu_stall     = r_alu_stall;
    assign err           = r_err;
    assign rf_we         = r_rf_we;
    assign rf_write_num  = r_rf_write_num;
    assign rf_input_data = r_rf_input_data;

endmodule

// File: tb/tb_reg_wb_ctrl.sv
// Self-checking bench for reg_wb_ctrl. Expected register-file writes are
// queued as stimulus is driven and compared by a negedge monitor.
module tb_reg_wb_ctrl;

    logic        clk;
    logic        rst_n;
    logic        alu_valid;
    logic [4:0]  alu_rd;
    logic [63:0] alu_data;
    logic        alu_stall;
    logic        mem_valid;
    logic        mem_ready;
    logic [4:0]  mem_rd;
    logic [63:0] mem_data;
    logic        ld_issue_valid;
    logic [4:0]  ld_issue_rd;
    logic [31:0] busy;
    logic        rf_we;
    logic [4:0]  rf_write_num;
    logic [63:0] rf_input_data;
    logic        err;

    typedef struct {
        logic [4:0]  num;
        logic [63:0] data;
    } wr_t;

    wr_t exp_q[$];
    int  checks   = 0;
    int  failures = 0;

    reg_wb_ctrl dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .alu_valid      (alu_valid),
        .alu_rd         (alu_rd),
        .alu_data       (alu_data),
        .alu_stall      (alu_stall),
        .mem_valid      (mem_valid),
        .mem_ready      (mem_ready),
        .mem_rd         (mem_rd),
        .mem_data       (mem_data),
        .ld_issue_valid (ld_issue_valid),
        .ld_issue_rd    (ld_issue_rd),
        .busy           (busy),
        .rf_we          (rf_we),
        .rf_write_num   (rf_write_num),
        .rf_input_data  (rf_input_data),
        .err            (err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, required completion");
        $fatal(1, "watchdog");
    end

    // Scoreboard monitor: every register-file write must match the queue head.
    always @(negedge clk) begin
        wr_t e;
        if (rst_n && rf_we) begin
            checks++;
            if (exp_q.size() == 0) begin
                failures++;
                $display("FAIL wb_unexpected: got num=%0d data=%h, required no write",
                         rf_write_num, rf_input_data);
            end else begin
                e = exp_q.pop_front();
                if (rf_write_num !== e.num || rf_input_data !== e.data) begin
                    failures++;
                    $display("FAIL wb_data: got num=%0d data=%h, required num=%0d data=%h",
                             rf_write_num, rf_input_data, e.num, e.data);
                end else begin
                    $display("wb num=%0d data=%h", rf_write_num, rf_input_data);
                end
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        alu_valid      = 1'b0;
        alu_rd         = '0;
        alu_data       = '0;
        mem_valid      = 1'b0;
        mem_rd         = '0;
        mem_data       = '0;
        ld_issue_valid = 1'b0;
        ld_issue_rd    = '0;
    endtask

    task automatic push_exp(input logic [4:0] num, input logic [63:0] data);
        wr_t e;
        e.num  = num;
        e.data = data;
        exp_q.push_back(e);
    endtask

    task automatic wait_drain(output bit ok);
        ok = 1'b0;
        for (int i = 0; i < 50; i++) begin
            if (exp_q.size() == 0) begin
                ok = 1'b1;
                break;
            end
            tick();
        end
        tick();
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        idle_inputs();
        repeat (2) @(posedge clk);
        #1;
        checks++;
        if (rf_we !== 1'b0 || rf_write_num !== 5'd0 || rf_input_data !== 64'd0 ||
            alu_stall !== 1'b0 || busy !== 32'd0 || err !== 1'b0) begin
            failures++;
            $display("FAIL reset_values: got we=%b num=%0d data=%h stall=%b busy=%h err=%b, required all zero",
                     rf_we, rf_write_num, rf_input_data, alu_stall, busy, err);
        end
        rst_n = 1'b1;
        tick();
        checks++;
        if (mem_ready !== 1'b1 || busy !== 32'd0) begin
            failures++;
            $display("FAIL reset_release: got mem_ready=%b busy=%h, required 1 and 0", mem_ready, busy);
        end
    endtask

    task automatic test_alu();
        bit ok;
        logic [4:0]  rd;
        logic [63:0] d;
        alu_valid = 1'b1;
        alu_rd    = 5'd5;
        alu_data  = 64'h0000_0000_DEAD_BEEF;
        push_exp(5'd5, 64'h0000_0000_DEAD_BEEF);
        tick();
        checks++;
        if (rf_we !== 1'b1 || rf_write_num !== 5'd5 || rf_input_data !== 64'h0000_0000_DEAD_BEEF) begin
            failures++;
            $display("FAIL alu_latency: got we=%b num=%0d data=%h, required we=1 num=5 data=deadbeef",
                     rf_we, rf_write_num, rf_input_data);
        end
        alu_rd   = 5'd0;
        alu_data = 64'h1111_2222_3333_4444;
        tick();
        checks++;
        if (rf_we !== 1'b0 || rf_write_num !== 5'd5) begin
            failures++;
            $display("FAIL alu_x0: got we=%b num=%0d, required we=0 num=5 held", rf_we, rf_write_num);
        end
        // Back-to-back ALU writes, one per cycle
        for (int i = 0; i < 6; i++) begin
            rd = 5'(1 + ($urandom % 31));
            d  = {$urandom, $urandom};
            alu_rd   = rd;
            alu_data = d;
            push_exp(rd, d);
            tick();
        end
        idle_inputs();
        wait_drain(ok);
        checks++;
        if (!ok) begin
            failures++;
            $display("FAIL alu_drain: got %0d writes pending, required 0", exp_q.size());
        end
    endtask

    task automatic test_load();
        ld_issue_valid = 1'b1;
        ld_issue_rd    = 5'd7;
        tick();
        ld_issue_valid = 1'b0;
        checks++;
        if (busy[7] !== 1'b1) begin
            failures++;
            $display("FAIL load_busy_set: got busy[7]=%b, required 1", busy[7]);
        end
        checks++;
        if (mem_ready !== 1'b1) begin
            failures++;
            $display("FAIL load_ready: got mem_ready=%b, required 1", mem_ready);
        end
        mem_valid = 1'b1;
        mem_rd    = 5'd7;
        mem_data  = 64'h1234;
        push_exp(5'd7, 64'h1234);
        tick();
        mem_valid = 1'b0;
        checks++;
        if (busy[7] !== 1'b1 || rf_we !== 1'b0) begin
            failures++;
            $display("FAIL load_accept: got busy[7]=%b we=%b, required 1 and 0", busy[7], rf_we);
        end
        tick();
        checks++;
        if (rf_we !== 1'b1 || rf_write_num !== 5'd7 || rf_input_data !== 64'h1234 || busy[7] !== 1'b0) begin
            failures++;
            $display("FAIL load_write: got we=%b num=%0d data=%h busy[7]=%b, required 1 7 1234 0",
                     rf_we, rf_write_num, rf_input_data, busy[7]);
        end
        tick();
        // A load to x0 is dropped and must never produce a write
        mem_valid = 1'b1;
        mem_rd    = 5'd0;
        mem_data  = 64'h5555;
        tick();
        mem_valid = 1'b0;
        tick();
        checks++;
        if (rf_we !== 1'b0) begin
            failures++;
            $display("FAIL load_x0: got we=%b, required 0", rf_we);
        end
        tick();
    endtask

    task automatic test_full_fifo();
        bit ok;
        logic [63:0] d;
        logic [63:0] ld_d [4];
        for (int i = 0; i < 4; i++) begin
            checks++;
            if (mem_ready !== 1'b1) begin
                failures++;
                $display("FAIL full_ready_early: got mem_ready=%b at count=%0d, required 1", mem_ready, i);
            end
            d = {$urandom, $urandom};
            alu_valid = 1'b1;
            alu_rd    = 5'(1 + i);
            alu_data  = d;
            push_exp(5'(1 + i), d);
            ld_d[i]   = {$urandom, $urandom};
            mem_valid = 1'b1;
            mem_rd    = 5'(10 + i);
            mem_data  = ld_d[i];
            tick();
        end
        checks++;
        if (mem_ready !== 1'b0 || alu_stall !== 1'b1) begin
            failures++;
            $display("FAIL full_flags: got mem_ready=%b stall=%b, required 0 and 1", mem_ready, alu_stall);
        end
        // Offer one more load while full: refused, no bypass
        alu_valid = 1'b0;
        mem_rd    = 5'd20;
        mem_data  = 64'hBAD0_BAD0;
        for (int i = 0; i < 4; i++) push_exp(5'(10 + i), ld_d[i]);
        tick();
        mem_valid = 1'b0;
        checks++;
        if (rf_we !== 1'b1 || rf_write_num !== 5'd10) begin
            failures++;
            $display("FAIL full_first_pop: got we=%b num=%0d, required we=1 num=10", rf_we, rf_write_num);
        end
        wait_drain(ok);
        checks++;
        if (!ok || mem_ready !== 1'b1 || alu_stall !== 1'b0) begin
            failures++;
            $display("FAIL full_drain: got pending=%0d mem_ready=%b stall=%b, required 0 1 0",
                     exp_q.size(), mem_ready, alu_stall);
        end
    endtask

    task automatic test_starvation();
        logic [63:0] d;
        logic [63:0] ld;
        bit ok;
        ld = 64'hCAFE_F00D_0000_0015;
        d  = {$urandom, $urandom};
        alu_valid = 1'b1;
        alu_rd    = 5'd2;
        alu_data  = d;
        push_exp(5'd2, d);
        mem_valid = 1'b1;
        mem_rd    = 5'd15;
        mem_data  = ld;
        tick();
        mem_valid = 1'b0;
        checks++;
        if (alu_stall !== 1'b0) begin
            failures++;
            $display("FAIL starve_early: got stall=%b after accept, required 0", alu_stall);
        end
        for (int i = 1; i <= 8; i++) begin
            d = {$urandom, $urandom};
            alu_rd   = 5'(16 + i);
            alu_data = d;
            push_exp(5'(16 + i), d);
            tick();
            checks++;
            if (alu_stall !== (i == 8)) begin
                failures++;
                $display("FAIL starve_stall: got stall=%b after %0d waits, required %0d",
                         alu_stall, i, (i == 8));
            end
        end
        checks++;
        if (err !== 1'b0) begin
            failures++;
            $display("FAIL starve_err_pre: got err=%b, required 0", err);
        end
        // Protocol violation: ALU keeps driving during the stall, result discarded
        alu_rd   = 5'd3;
        alu_data = 64'hDEAD_0000_DEAD_0000;
        push_exp(5'd15, ld);
        tick();
        alu_valid = 1'b0;
        checks++;
        if (rf_we !== 1'b1 || rf_write_num !== 5'd15 || err !== 1'b1 || alu_stall !== 1'b0) begin
            failures++;
            $display("FAIL starve_pop: got we=%b num=%0d err=%b stall=%b, required 1 15 1 0",
                     rf_we, rf_write_num, err, alu_stall);
        end
        wait_drain(ok);
        checks++;
        if (!ok) begin
            failures++;
            $display("FAIL starve_drain: got %0d pending, required 0", exp_q.size());
        end
    endtask

    task automatic test_reset_mid();
        logic [63:0] d;
        ld_issue_valid = 1'b1;
        ld_issue_rd    = 5'd20;
        tick();
        ld_issue_rd    = 5'd21;
        tick();
        ld_issue_valid = 1'b0;
        for (int i = 0; i < 3; i++) begin
            d = {$urandom, $urandom};
            alu_valid = 1'b1;
            alu_rd    = 5'(4 + i);
            alu_data  = d;
            if (i < 2) push_exp(5'(4 + i), d);
            mem_valid = (i < 2);
            mem_rd    = 5'(20 + i);
            mem_data  = {$urandom, $urandom};
            tick();
        end
        idle_inputs();
        checks++;
        if (rf_we !== 1'b1 || busy[20] !== 1'b1 || busy[21] !== 1'b1 || err !== 1'b1) begin
            failures++;
            $display("FAIL midrst_pre: got we=%b busy20=%b busy21=%b err=%b, required 1 1 1 1",
                     rf_we, busy[20], busy[21], err);
        end
        #2;
        rst_n = 1'b0;
        #1;
        checks++;
        if (rf_we !== 1'b0 || rf_write_num !== 5'd0 || rf_input_data !== 64'd0 ||
            busy !== 32'd0 || alu_stall !== 1'b0 || err !== 1'b0) begin
            failures++;
            $display("FAIL midrst_async: got we=%b num=%0d data=%h busy=%h stall=%b err=%b, required zeros",
                     rf_we, rf_write_num, rf_input_data, busy, alu_stall, err);
        end
        @(negedge clk);
        rst_n = 1'b1;
        tick();
        checks++;
        if (mem_ready !== 1'b1 || busy !== 32'd0) begin
            failures++;
            $display("FAIL midrst_release: got mem_ready=%b busy=%h, required 1 and 0", mem_ready, busy);
        end
        // Discarded FIFO entries must never reach the register file
        repeat (12) tick();
        checks++;
        if (exp_q.size() != 0) begin
            failures++;
            $display("FAIL midrst_pending: got %0d pending, required 0", exp_q.size());
        end
    endtask

    task automatic test_collision();
        bit ok;
        ld_issue_valid = 1'b1;
        ld_issue_rd    = 5'd9;
        tick();
        ld_issue_valid = 1'b0;
        checks++;
        if (busy[9] !== 1'b1 || err !== 1'b0) begin
            failures++;
            $display("FAIL coll_setup: got busy[9]=%b err=%b, required 1 and 0", busy[9], err);
        end
        mem_valid = 1'b1;
        mem_rd    = 5'd9;
        mem_data  = 64'hAAAA;
        push_exp(5'd9, 64'hAAAA);
        tick();
        mem_valid      = 1'b0;
        ld_issue_valid = 1'b1;
        ld_issue_rd    = 5'd9;
        tick();
        ld_issue_valid = 1'b0;
        checks++;
        if (rf_we !== 1'b1 || rf_write_num !== 5'd9 || busy[9] !== 1'b1 || err !== 1'b1) begin
            failures++;
            $display("FAIL coll_set_wins: got we=%b num=%0d busy[9]=%b err=%b, required 1 9 1 1",
                     rf_we, rf_write_num, busy[9], err);
        end
        mem_valid = 1'b1;
        mem_rd    = 5'd9;
        mem_data  = 64'hBBBB;
        push_exp(5'd9, 64'hBBBB);
        tick();
        mem_valid = 1'b0;
        tick();
        checks++;
        if (busy[9] !== 1'b0) begin
            failures++;
            $display("FAIL coll_clear: got busy[9]=%b, required 0", busy[9]);
        end
        wait_drain(ok);
        checks++;
        if (!ok) begin
            failures++;
            $display("FAIL coll_drain: got %0d pending, required 0", exp_q.size());
        end
    endtask

    initial begin
        test_reset();
        test_alu();
        test_load();
        test_full_fifo();
        test_starvation();
        test_reset_mid();
        test_collision();
        repeat (3) tick();
        checks++;
        if (exp_q.size() != 0) begin
            failures++;
            $display("FAIL final_pending: got %0d pending, required 0", exp_q.size());
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
